// File: rtl/mem_model_bwe.sv
// Simple dual-port byte-write-enable memory with address-sweep clear on reset.
// Define MEM_FAULT_INJ_EN to add stuck-at fault injection ports on the read path.
module mem_model_bwe #(
    parameter int unsigned        DWIDTH     = 32,
    parameter int unsigned        AWIDTH     = 10,
    parameter int unsigned        RD_LATENCY = 1,
    parameter int unsigned        RDW_MODE   = 0,
    parameter logic [DWIDTH-1:0]  INIT_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AWIDTH-1:0]     wraddr,
    input  logic [DWIDTH/8-1:0]   be,
    input  logic [DWIDTH-1:0]     datain,
    input  logic                  re,
    input  logic [AWIDTH-1:0]     rdaddr,
`ifdef MEM_FAULT_INJ_EN
    input  logic                  fi_en,
    input  logic [AWIDTH-1:0]     fi_addr,
    input  logic [$clog2(DWIDTH)-1:0] fi_bit,
    input  logic                  fi_val,
`endif
    output logic [DWIDTH-1:0]     dataout,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  req_drop
);

    localparam int unsigned NBYTES = DWIDTH / 8;
    localparam int unsigned DEPTH  = 2 ** AWIDTH;

    typedef enum logic {CLEAR, IDLE} state_t;

    logic [DWIDTH-1:0] mem [DEPTH];
    state_t            state;
    logic [AWIDTH-1:0] clr_addr;
    logic [DWIDTH-1:0] wmask;
    logic [DWIDTH-1:0] wr_word;
    logic [DWIDTH-1:0] rd_word;
    logic              accept_wr;
    logic              accept_rd;
    logic              p_valid;
    logic [DWIDTH-1:0] p_data;

    for (genvar g = 0; g < NBYTES; g++) begin : g_mask
        assign wmask[8*g +: 8] = {8{be[g]}};
    end

    always_comb begin
        accept_wr = (state == IDLE) && we;
        accept_rd = (state == IDLE) && re;
        wr_word   = (mem[wraddr] & ~wmask) | (datain & wmask);
        rd_word   = mem[rdaddr];
        // New-data mode forwards the byte-merged write word on a same-address collision
        if (RDW_MODE == 1 && accept_wr && wraddr == rdaddr)
            rd_word = wr_word;
`ifdef MEM_FAULT_INJ_EN
        if (fi_en && rdaddr == fi_addr)
            rd_word[fi_bit] = fi_val;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                mem[clr_addr] <= INIT_VAL;
            else if (we)
                mem[wraddr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
            req_drop <= 1'b0;
            dataout  <= '0;
            rd_valid <= 1'b0;
            p_valid  <= 1'b0;
            p_data   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    req_drop <= we | re;
                    if (clr_addr == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: req_drop <= 1'b0;
            endcase

            if (RD_LATENCY == 1) begin
                rd_valid <= accept_rd;
                if (accept_rd)
                    dataout <= rd_word;
            end else begin
                p_valid  <= accept_rd;
                if (accept_rd)
                    p_data <= rd_word;
                rd_valid <= p_valid;
                if (p_valid)
                    dataout <= p_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_model_bwe.sv
// Bench for mem_model_bwe: two instances (latency 1/old-data, latency 2/new-data)
// checked every cycle against a queue-based reference model.
module tb_mem_model_bwe;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] INIT0 = 32'h0000_0000;
    localparam logic [31:0] INIT1 = 32'h5A5A_A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, re;
    logic [9:0]  wraddr, rdaddr;
    logic [3:0]  be;
    logic [31:0] datain;
    logic [31:0] dout0, dout1;
    logic        v0, v1, b0, b1, d0, d1;
`ifdef MEM_FAULT_INJ_EN
    logic        fi_en;
    logic [9:0]  fi_addr;
    logic [4:0]  fi_bit;
    logic        fi_val;
`endif

    mem_model_bwe #(.DWIDTH(32), .AWIDTH(10), .RD_LATENCY(1), .RDW_MODE(0), .INIT_VAL(INIT0)) u0 (
        .clk(clk), .rst(rst), .we(we), .wraddr(wraddr), .be(be), .datain(datain),
        .re(re), .rdaddr(rdaddr),
`ifdef MEM_FAULT_INJ_EN
        .fi_en(fi_en), .fi_addr(fi_addr), .fi_bit(fi_bit), .fi_val(fi_val),
`endif
        .dataout(dout0), .rd_valid(v0), .busy(b0), .req_drop(d0));

    mem_model_bwe #(.DWIDTH(32), .AWIDTH(10), .RD_LATENCY(2), .RDW_MODE(1), .INIT_VAL(INIT1)) u1 (
        .clk(clk), .rst(rst), .we(we), .wraddr(wraddr), .be(be), .datain(datain),
        .re(re), .rdaddr(rdaddr),
`ifdef MEM_FAULT_INJ_EN
        .fi_en(fi_en), .fi_addr(fi_addr), .fi_bit(fi_bit), .fi_val(fi_val),
`endif
        .dataout(dout1), .rd_valid(v1), .busy(b1), .req_drop(d1));

    typedef struct { int due; logic [31:0] d; } rd_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          swept = 0;
    int          n;
    rd_t         q0[$], q1[$];
    logic [31:0] m0[DEPTH], m1[DEPTH];
    logic [31:0] ed0 = '0, ed1 = '0;
    logic        ev0 = 1'b0, ev1 = 1'b0, eb = 1'b1, edrop = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] en);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] fault(input logic [31:0] w, input logic [9:0] a);
        logic [31:0] r;
        r = w;
`ifdef MEM_FAULT_INJ_EN
        if (fi_en && a == fi_addr) r[fi_bit] = fi_val;
`else
        if (a === 10'bx) r = 'x;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock edge: advance the reference model, then compare all outputs.
    task automatic tick();
        rd_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            swept = 0;
            q0.delete();
            q1.delete();
            ed0 = '0;
            ed1 = '0;
            edrop = 1'b0;
        end else if (swept < DEPTH) begin
            edrop = we || re;
            m0[swept] = INIT0;
            m1[swept] = INIT1;
            swept++;
        end else begin
            edrop = 1'b0;
            if (re) begin
                e.due = cyc;
                e.d = fault(m0[rdaddr], rdaddr);
                q0.push_back(e);
                e.due = cyc + 1;
                e.d = fault((we && wraddr == rdaddr) ? merge(m1[rdaddr], datain, be) : m1[rdaddr], rdaddr);
                q1.push_back(e);
            end
            if (we) begin
                m0[wraddr] = merge(m0[wraddr], datain, be);
                m1[wraddr] = merge(m1[wraddr], datain, be);
            end
        end
        ev0 = (q0.size() > 0) && (q0[0].due == cyc);
        if (ev0) begin e = q0.pop_front(); ed0 = e.d; end
        ev1 = (q1.size() > 0) && (q1[0].due == cyc);
        if (ev1) begin e = q1.pop_front(); ed1 = e.d; end
        eb = rst || (swept < DEPTH);
        chk("u0_dataout", dout0, ed0);
        chk("u0_rd_valid", 32'(v0), 32'(ev0));
        chk("u0_busy", 32'(b0), 32'(eb));
        chk("u0_req_drop", 32'(d0), 32'(edrop));
        chk("u1_dataout", dout1, ed1);
        chk("u1_rd_valid", 32'(v1), 32'(ev1));
        chk("u1_busy", 32'(b1), 32'(eb));
        chk("u1_req_drop", 32'(d1), 32'(edrop));
    endtask

    task automatic rand_req(input int amax);
        we     = 1'($urandom_range(0, 1));
        re     = 1'($urandom_range(0, 1));
        wraddr = 10'($urandom_range(0, amax));
        rdaddr = 10'($urandom_range(0, amax));
        be     = 4'($urandom);
        datain = $urandom;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; wraddr = '0; rdaddr = '0; be = '0; datain = '0;
`ifdef MEM_FAULT_INJ_EN
        fi_en = 1'b0; fi_addr = '0; fi_bit = '0; fi_val = 1'b0;
`endif
        repeat (3) tick();

        // Sweep interrupted at clr_addr=500, requests arriving throughout
        rst = 1'b0;
        repeat (500) begin rand_req(1023); tick(); end
        rst = 1'b1; we = 1'b0; re = 1'b0;
        tick();
        rst = 1'b0;
        n = 0;
        while (b0 && n < 2000) begin rand_req(1023); tick(); n++; end
        chk("busy_len_restart", n, 1024);

        we = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin re = 1'b1; rdaddr = 10'(a); tick(); end
        re = 1'b0;
        repeat (2) tick();

        // Byte enables
        we = 1'b1; wraddr = 10'd5; datain = 32'hAABB_CCDD; be = 4'b1111; tick();
        datain = 32'h1122_3344; be = 4'b0101; tick();
        we = 1'b0; re = 1'b1; rdaddr = 10'd5; tick();
        chk("be_u0", dout0, 32'hAA22_CC44);
        re = 1'b0; tick();
        chk("be_u1", dout1, 32'hAA22_CC44);
        tick();

        // Latency on addr 7, then four back-to-back reads
        re = 1'b1; rdaddr = 10'd7; tick();
        chk("lat2_not_yet", 32'(v1), 32'd0);
        re = 1'b0; tick();
        chk("lat2_valid", 32'(v1), 32'd1);
        for (int a = 0; a < 4; a++) begin re = 1'b1; rdaddr = 10'(10 + a); tick(); end
        re = 1'b0;
        n = 0;
        repeat (2) begin tick(); n += int'(v1); end
        chk("b2b_tail_valid", n, 1);

        // Read-during-write on addr 9
        we = 1'b1; wraddr = 10'd9; datain = 32'h0; be = 4'b1111; tick();
        datain = 32'hFFFF_FFFF; be = 4'b0011; re = 1'b1; rdaddr = 10'd9; tick();
        chk("rdw_old", dout0, 32'h0000_0000);
        we = 1'b0; re = 1'b0; tick();
        chk("rdw_new", dout1, 32'h0000_FFFF);

        // Read in flight when reset asserts is dropped
        re = 1'b1; rdaddr = 10'd9; tick();
        re = 1'b0; rst = 1'b1; tick();
        chk("flush_no_valid", 32'(v1), 32'd0);
        rst = 1'b0;
        n = 0;
        while (b0 && n < 2000) begin rand_req(1023); tick(); n++; end
        chk("busy_len", n, 1024);

        repeat (3000) begin rand_req(15); tick(); end
        we = 1'b0; re = 1'b0;
        repeat (2) tick();

`ifdef MEM_FAULT_INJ_EN
        fi_en = 1'b1; fi_addr = 10'd3; fi_bit = 5'd0; fi_val = 1'b1;
        we = 1'b1; wraddr = 10'd3; datain = 32'h0; be = 4'b1111; tick();
        we = 1'b0; re = 1'b1; rdaddr = 10'd3; tick();
        chk("fi_on", dout0, 32'h0000_0001);
        re = 1'b0; tick();
        fi_en = 1'b0; re = 1'b1; tick();
        chk("fi_off", dout0, 32'h0000_0000);
        re = 1'b0; repeat (2) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
